// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared state encoding and default width for the serial subtractor
package sub_pkg;

  localparam int SUB_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit full subtractor x - y - bi
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic diff,
  output logic bo
);

  assign diff = x ^ y ^ bi;
  assign bo   = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor; SUB_OVF_EN adds the signed-overflow output ovf
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic [CW-1:0]    cnt;
  logic             brw;
  logic             fs_diff, fs_bo;
  logic             accept, last_bit;

  full_subtractor u_fs (
    .x   (a_sh[0]),
    .y   (b_sh[0]),
    .bi  (brw),
    .diff(fs_diff),
    .bo  (fs_bo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    last_bit = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == LAST) begin
          last_bit = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // The final bit is folded straight into d/bout so the result is visible in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      res  <= '0;
      cnt  <= '0;
      brw  <= 1'b0;
      d    <= '0;
      bout <= 1'b0;
`ifdef SUB_OVF_EN
      ovf  <= 1'b0;
`endif
    end else if (accept) begin
      a_sh <= a;
      b_sh <= b;
      brw  <= bin;
      cnt  <= '0;
    end else if (state == SHIFT) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      brw  <= fs_bo;
      res  <= {fs_diff, res[WIDTH-1:1]};
      if (last_bit) begin
        d    <= {fs_diff, res[WIDTH-1:1]};
        bout <= fs_bo;
`ifdef SUB_OVF_EN
        ovf  <= brw ^ fs_bo;
`endif
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor with an arithmetic reference model
module tb_serial_subtractor;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  typedef struct {
    int d;
    int bout;
    int ovf;
    int done_cyc;
  } exp_t;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         bin   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy, done, bout;
  logic [W-1:0] d;
`ifdef SUB_OVF_EN
  logic         ovf;
`endif

  int   cyc = 0;
  int   pass_cnt = 0;
  int   chk_cnt = 0;
  int   last_acc = -100;
  int   hold_d = 0, hold_bout = 0, hold_ovf = 0;
  int   pushed = 0, popped = 0;
  exp_t q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .d    (d),
    .bout (bout)
`ifdef SUB_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
  endtask

  function automatic exp_t model(input int av, input int bv, input int biv, input int acc);
    exp_t e;
    int   sa, sb, r;
    e.d    = (av - bv - biv) & MASK;
    e.bout = (av < bv + biv) ? 1 : 0;
    sa     = (av >= (1 << (W - 1))) ? av - (1 << W) : av;
    sb     = (bv >= (1 << (W - 1))) ? bv - (1 << W) : bv;
    r      = sa - sb - biv;
    e.ovf  = (r < -(1 << (W - 1)) || r > (1 << (W - 1)) - 1) ? 1 : 0;
    e.done_cyc = acc + W;
    return e;
  endfunction

  // Monitor: done must fall exactly W cycles after the accepting edge; outputs hold otherwise.
  always @(negedge clk) begin
    exp_t e;
    check("busy", {31'b0, busy}, (cyc >= last_acc && cyc <= last_acc + W) ? 1 : 0);
    check("done", {31'b0, done}, (cyc == last_acc + W) ? 1 : 0);
    if (done && q.size() > 0) begin
      e = q.pop_front();
      popped++;
      check("done_cycle", cyc, e.done_cyc);
      hold_d    = e.d;
      hold_bout = e.bout;
      hold_ovf  = e.ovf;
    end
    check("d", {{(32-W){1'b0}}, d}, hold_d);
    check("bout", {31'b0, bout}, hold_bout);
`ifdef SUB_OVF_EN
    check("ovf", {31'b0, ovf}, hold_ovf);
`endif
  end

  task automatic drive(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic biv, output bit acc);
    start = s;
    a     = av;
    b     = bv;
    bin   = biv;
    acc   = s && (cyc + 1 >= last_acc + W + 2);
    if (acc) last_acc = cyc + 1;
    @(negedge clk);
  endtask

  task automatic rand_step(input logic s);
    bit           acc;
    logic [W-1:0] av, bv;
    logic         biv;
    av  = W'($urandom);
    bv  = W'($urandom);
    biv = 1'($urandom);
    drive(s, av, bv, biv, acc);
    if (acc) begin
      q.push_back(model(int'(av), int'(bv), int'(biv), last_acc));
      pushed++;
    end
  endtask

  task automatic dir_op(input int av, input int bv, input int biv,
                        input int ed, input int eb, input int eo);
    bit   acc;
    exp_t e;
    while (cyc + 1 < last_acc + W + 2) drive(1'b0, W'($urandom), W'($urandom), 1'b0, acc);
    drive(1'b1, W'(av), W'(bv), 1'(biv), acc);
    if (acc) begin
      e.d = ed; e.bout = eb; e.ovf = eo; e.done_cyc = last_acc + W;
      q.push_back(e);
      pushed++;
    end else begin
      check("dir_accept", 0, 1);
    end
  endtask

  initial begin
    bit acc;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    dir_op(5, 0, 1, 4, 0, 0);
    dir_op(3, 5, 0, 14, 1, 0);
    dir_op(0, 0, 1, 15, 1, 0);
    dir_op(8, 1, 0, 7, 0, 1);

    // Start held high with operands changing every cycle.
    repeat (5 * (W + 2)) rand_step(1'b1);
    repeat (200) rand_step(1'($urandom_range(0, 1)));

    // Reset two cycles into an operation aborts it.
    dir_op(0, 0, 1, 15, 1, 0);
    while (cyc + 1 < last_acc + W + 2) drive(1'b0, '0, '0, 1'b0, acc);
    rand_step(1'b1);
    drive(1'b0, '0, '0, 1'b0, acc);
    #2;
    rst_n     = 1'b0;
    pushed   -= q.size();
    q.delete();
    last_acc  = -100;
    hold_d    = 0;
    hold_bout = 0;
    hold_ovf  = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    dir_op(3, 5, 0, 14, 1, 0);
    dir_op(8, 1, 0, 7, 0, 1);
    repeat (50) rand_step(1'($urandom_range(0, 1)));

    start = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    check("drain", q.size(), 0);
    check("done_count", popped, pushed);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result width in bits; legal values 2..32.
REQ-002 Port: clk  input  1  rising-edge clock; all state changes on posedge clk.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: start  input  1  request pulse or level; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  minuend; sampled on the accepted start cycle only.
REQ-006 Port: b  input  WIDTH  subtrahend; sampled on the accepted start cycle only.
REQ-007 Port: bin  input  1  borrow-in; sampled on the accepted start cycle only.
REQ-008 Port: busy  output  1  high in states SHIFT and DONE.
REQ-009 Port: done  output  1  single-cycle pulse, high in state DONE.
REQ-010 Port: d  output  WIDTH  difference; holds its value until the next done.
REQ-011 Port: bout  output  1  borrow-out; holds its value until the next done.
REQ-012 Port: ovf  output  1  signed overflow; present only when SUB_OVF_EN is defined.

Function
REQ-013 FSM states: IDLE, SHIFT, DONE (encoding 2 bits).
REQ-014 IDLE with start=1: capture a, b into shift registers; borrow register = bin; bit counter = 0; next state SHIFT.
REQ-015 IDLE with start=0: remain in IDLE; d and bout hold.
REQ-016 SHIFT: process one bit per cycle, LSB first.
REQ-017 SHIFT bit rule: diff = a_i ^ b_i ^ brw; brw' = (~a_i & b_i) | (~(a_i ^ b_i) & brw).
REQ-018 SHIFT: each diff bit shifts into the result register MSB side; operand registers shift right; counter increments.
REQ-019 SHIFT: when the counter equals WIDTH-1, that bit is processed and the next state is DONE.
REQ-020 Entering DONE: d <= completed result register; bout <= final borrow; done = 1 for exactly one cycle.
REQ-021 DONE: next state is always IDLE.
REQ-022 Latency: start accepted at edge t -> done high in cycle t+WIDTH+1; back-to-back throughput is one operation per WIDTH+2 cycles.
REQ-023 Arithmetic: d = (a - b - bin) mod 2^WIDTH; bout = 1 iff a < b + bin (unsigned).
REQ-024 start while busy (SHIFT or DONE): ignored; no queueing; the operation in flight is unaffected.
REQ-025 a, b and bin changes after the accepted start cycle have no effect on the result.
REQ-026 Counter width: clog2(WIDTH); no wrap occurs because the exit condition is checked before increment.

Reset
REQ-027 rst_n low: asynchronously force state IDLE, all shift/counter/borrow registers 0, d=0, bout=0, busy=0, done=0, ovf=0.
REQ-028 Reset asserted mid-operation aborts the operation; no done is produced for it.
REQ-029 After rst_n deasserts, the first start is accepted on the first posedge with start=1.

Configuration
REQ-030 Macro SUB_OVF_EN defined: add port ovf, updated in DONE alongside d/bout, = borrow into MSB XOR borrow out of MSB; holds between operations.
REQ-031 Macro SUB_OVF_EN undefined: no ovf port, no MSB-borrow register; all other behaviour identical.

Structure
REQ-032 Shared package sub_pkg: state enum (IDLE/SHIFT/DONE) and default WIDTH constant.
REQ-033 One sub-module, full_subtractor (inputs x, y, bi; outputs diff, bo), implements REQ-017 and is instantiated once.

Verification
REQ-034 WIDTH=4: a=5, b=0, bin=1 -> done at start+5 cycles, d=4, bout=0, ovf=0.
REQ-035 a=3, b=5, bin=0 -> d=14, bout=1, ovf=0.
REQ-036 a=0, b=0, bin=1 -> d=15, bout=1 (borrow wrap-around).
REQ-037 a=8, b=1, bin=0 -> d=7, bout=0, ovf=1 (-8-1 overflows; macro build only).
REQ-038 start held high for the whole operation with a/b changing every cycle -> exactly one done per WIDTH+2 cycles; each result matches operands captured at acceptance.
REQ-039 rst_n pulsed low two cycles after start -> busy=0, d=0, bout=0, no done pulse; next start computes correctly.
